// File: rtl/eth_rx_header_parser_if.sv
// Byte-wide AXI4-Stream bundle used on both sides of eth_rx_header_parser.
interface eth_rx_header_parser_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/eth_rx_header_parser.sv
// Strips and latches the 14-byte Ethernet header and forwards the payload through one register.
// Optional destination-address filter enabled by defining ETH_RX_MAC_FILTER_EN.
module eth_rx_header_parser #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01
) (
  input  logic                  clk,
  input  logic                  rst_n,
  eth_rx_header_parser_if.slave  s_axis,
  eth_rx_header_parser_if.master m_axis,
  output logic [47:0]           hdr_dst_mac,
  output logic [47:0]           hdr_src_mac,
  output logic [15:0]           hdr_ethertype,
  output logic                  hdr_valid,
  output logic                  frame_drop
);

  if (DATA_WIDTH != 8) begin : g_width_check
    $error("eth_rx_header_parser: DATA_WIDTH must be 8");
  end

  typedef enum logic [1:0] {StHdr, StPayload, StDrop} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [47:0]           dst_q, src_q;
  logic [15:0]           type_q;
  logic                  hdr_valid_q, hdr_valid_d;
  logic                  frame_drop_q, frame_drop_d;
  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_last_q;
  logic                  s_ready, accept, hdr_last, filter_ok, load;

  // Ready never depends on s_axis.tvalid.
  assign s_ready  = (state_q != StPayload) || !m_valid_q || m_axis.tready;
  assign accept   = s_axis.tvalid && s_ready;
  assign hdr_last = (cnt_q == 4'd13);

`ifdef ETH_RX_MAC_FILTER_EN
  // dst_q is complete by the time byte 13 is being decided.
  assign filter_ok = (dst_q == LOCAL_MAC) || (&dst_q) || dst_q[40];
`else
  logic unused_local_mac;
  assign unused_local_mac = ^LOCAL_MAC;
  assign filter_ok        = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StHdr;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHdr: begin
        if (accept && !s_axis.tlast && hdr_last) begin
          state_d = filter_ok ? StPayload : StDrop;
        end
      end
      StPayload, StDrop: begin
        if (accept && s_axis.tlast) begin
          state_d = StHdr;
        end
      end
      default: state_d = StHdr;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    hdr_valid_d  = 1'b0;
    frame_drop_d = 1'b0;
    load         = 1'b0;
    unique case (state_q)
      StHdr: begin
        if (accept) begin
          cnt_d = cnt_q + 4'd1;
          if (s_axis.tlast) begin
            frame_drop_d = 1'b1;
            cnt_d        = 4'd0;
          end else if (hdr_last) begin
            cnt_d        = 4'd0;
            hdr_valid_d  = filter_ok;
            frame_drop_d = !filter_ok;
          end
        end
      end
      StPayload: load = accept;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= 4'd0;
      dst_q        <= 48'd0;
      src_q        <= 48'd0;
      type_q       <= 16'd0;
      hdr_valid_q  <= 1'b0;
      frame_drop_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      hdr_valid_q  <= hdr_valid_d;
      frame_drop_q <= frame_drop_d;
      if (state_q == StHdr && accept) begin
        if (cnt_q < 4'd6) begin
          dst_q <= {dst_q[39:0], s_axis.tdata};
        end else if (cnt_q < 4'd12) begin
          src_q <= {src_q[39:0], s_axis.tdata};
        end else begin
          type_q <= {type_q[7:0], s_axis.tdata};
        end
      end
      if (load) begin
        m_valid_q <= 1'b1;
        m_data_q  <= s_axis.tdata;
        m_last_q  <= s_axis.tlast;
      end else if (m_axis.tready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tdata  = m_data_q;
  assign m_axis.tlast  = m_last_q;
  assign hdr_dst_mac   = dst_q;
  assign hdr_src_mac   = src_q;
  assign hdr_ethertype = type_q;
  assign hdr_valid     = hdr_valid_q;
  assign frame_drop    = frame_drop_q;

endmodule

// File: tb/tb_eth_rx_header_parser.sv
// Directed self-checking bench for eth_rx_header_parser.
module tb_eth_rx_header_parser;

  localparam logic [47:0] LocalMac = 48'h02_00_00_00_00_01;
  localparam logic [47:0] SrcMac   = 48'h00_11_22_33_44_55;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] hdr_dst_mac, hdr_src_mac;
  logic [15:0] hdr_ethertype;
  logic        hdr_valid, frame_drop;

  always #5 clk = ~clk;

  eth_rx_header_parser_if #(.DATA_WIDTH(8)) s_if ();
  eth_rx_header_parser_if #(.DATA_WIDTH(8)) m_if ();

  eth_rx_header_parser #(
    .DATA_WIDTH(8),
    .LOCAL_MAC (LocalMac)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .hdr_dst_mac  (hdr_dst_mac),
    .hdr_src_mac  (hdr_src_mac),
    .hdr_ethertype(hdr_ethertype),
    .hdr_valid    (hdr_valid),
    .frame_drop   (frame_drop)
  );

  int errors = 0;
  int checks = 0;

  // Monitor state, written only by the negedge sampler.
  int          cyc = 0;
  int          hv_cnt = 0;
  int          fd_cnt = 0;
  int          out_n = 0;
  logic [8:0]  out_word [0:1023];
  int          out_cyc [0:1023];
  logic [47:0] cap_dst = '0, cap_src = '0;
  logic [15:0] cap_type = '0;
  int          stall_viol = 0;
  int          ready_viol = 0;
  int          s_stalls = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  logic        prev_last = 1'b0;

  // Backpressure driver control.
  logic       bp_en = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int         bp_i = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (hdr_valid) begin
        hv_cnt   <= hv_cnt + 1;
        cap_dst  <= hdr_dst_mac;
        cap_src  <= hdr_src_mac;
        cap_type <= hdr_ethertype;
      end
      if (frame_drop) fd_cnt <= fd_cnt + 1;
      if (m_if.tvalid && m_if.tready) begin
        out_word[out_n] <= {m_if.tlast, m_if.tdata};
        out_cyc[out_n]  <= cyc;
        out_n           <= out_n + 1;
      end
      if (prev_stall && (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_data ||
                         m_if.tlast !== prev_last)) begin
        stall_viol <= stall_viol + 1;
      end
      if (!s_if.tready) begin
        s_stalls <= s_stalls + 1;
        if (!(m_if.tvalid && !m_if.tready)) ready_viol <= ready_viol + 1;
      end
      prev_stall <= m_if.tvalid && !m_if.tready;
      prev_data  <= m_if.tdata;
      prev_last  <= m_if.tlast;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (bp_en) begin
        m_if.tready = bp_pat[bp_i];
        bp_i = (bp_i + 1) % 4;
      end else begin
        m_if.tready = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte is accepted.
  task automatic send_byte(input logic [7:0] d, input logic last);
    logic ok;
    int   guard;
    guard = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tlast  = last;
    forever begin
      @(negedge clk);
      ok = s_if.tready;
      @(posedge clk);
      #1;
      if (ok) break;
      guard++;
      if (guard > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: observed no accept expected accept within 200 cycles");
        break;
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] etype, input int n, input logic [7:0] base);
    logic [111:0] hdr;
    hdr = {dst, src, etype};
    for (int i = 0; i < 14; i++) send_byte(hdr[111-8*i -: 8], (i == 13) && (n == 0));
    for (int i = 0; i < n; i++) send_byte(base + 8'(i), i == n - 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_payload(input string tag, input int first, input int n,
                               input logic [7:0] base);
    check({tag, "_count"}, 64'(out_n - first), 64'(n));
    if (out_n - first == n) begin
      for (int i = 0; i < n; i++) begin
        check({tag, "_byte"}, 64'(out_word[first+i]), 64'({i == n - 1, base + 8'(i)}));
      end
    end
  endtask

  int hv0, fd0, o0;

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    #1;
    check("rst_s_ready", 64'(s_if.tready), 64'd1);
    check("rst_m_valid", 64'(m_if.tvalid), 64'd0);
    check("rst_m_data", 64'(m_if.tdata), 64'd0);
    check("rst_m_last", 64'(m_if.tlast), 64'd0);
    check("rst_dst", 64'(hdr_dst_mac), 64'd0);
    check("rst_src", 64'(hdr_src_mac), 64'd0);
    check("rst_type", 64'(hdr_ethertype), 64'd0);
    check("rst_hdr_valid", 64'(hdr_valid), 64'd0);
    check("rst_frame_drop", 64'(frame_drop), 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unicast 64-byte frame, ready held high.
    hv0 = hv_cnt; fd0 = fd_cnt; o0 = out_n;
    send_frame(LocalMac, SrcMac, 16'h0800, 50, 8'h00);
    idle(4);
    check("uni_hv", 64'(hv_cnt - hv0), 64'd1);
    check("uni_fd", 64'(fd_cnt - fd0), 64'd0);
    check("uni_dst", 64'(cap_dst), 64'(LocalMac));
    check("uni_src", 64'(cap_src), 64'(SrcMac));
    check("uni_type", 64'(cap_type), 64'h0800);
    check_payload("uni", o0, 50, 8'h00);
    if (out_n - o0 == 50) check("uni_no_bubble", 64'(out_cyc[o0+49] - out_cyc[o0]), 64'd49);
    check("uni_hold_src", 64'(hdr_src_mac), 64'(SrcMac));

    // Same frame under 1,0,0,1 backpressure.
    hv0 = hv_cnt; o0 = out_n;
    bp_en = 1'b1;
    send_frame(LocalMac, SrcMac, 16'h0800, 50, 8'h00);
    idle(8);
    bp_en = 1'b0;
    idle(2);
    check("bp_hv", 64'(hv_cnt - hv0), 64'd1);
    check_payload("bp", o0, 50, 8'h00);
    check("bp_stall_stable", 64'(stall_viol), 64'd0);
    check("bp_ready_rule", 64'(ready_viol), 64'd0);
    check("bp_stalled_some", 64'(s_stalls > 0), 64'd1);

    // Runt: 10 bytes, tlast on byte 9, then a valid frame.
    hv0 = hv_cnt; fd0 = fd_cnt; o0 = out_n;
    for (int i = 0; i < 10; i++) send_byte(8'h40 + 8'(i), i == 9);
    idle(3);
    check("runt_fd", 64'(fd_cnt - fd0), 64'd1);
    check("runt_hv", 64'(hv_cnt - hv0), 64'd0);
    check("runt_no_out", 64'(out_n - o0), 64'd0);
    o0 = out_n;
    send_frame(LocalMac, 48'hAA_BB_CC_DD_EE_FF, 16'h86DD, 4, 8'hA0);
    idle(3);
    check("post_runt_hv", 64'(hv_cnt - hv0), 64'd1);
    check("post_runt_src", 64'(cap_src), 64'hAA_BB_CC_DD_EE_FF);
    check("post_runt_type", 64'(cap_type), 64'h86DD);
    check_payload("post_runt", o0, 4, 8'hA0);

    // Zero-payload frame: tlast on byte 13.
    hv0 = hv_cnt; fd0 = fd_cnt; o0 = out_n;
    send_frame(LocalMac, SrcMac, 16'h0806, 0, 8'h00);
    idle(3);
    check("zero_pl_fd", 64'(fd_cnt - fd0), 64'd1);
    check("zero_pl_hv", 64'(hv_cnt - hv0), 64'd0);
    check("zero_pl_no_out", 64'(out_n - o0), 64'd0);

    // Mis-addressed, broadcast and multicast frames.
    hv0 = hv_cnt; fd0 = fd_cnt; o0 = out_n;
    send_frame(48'h02_00_00_00_00_99, SrcMac, 16'h0800, 5, 8'h10);
    idle(3);
`ifdef ETH_RX_MAC_FILTER_EN
    check("filt_fd", 64'(fd_cnt - fd0), 64'd1);
    check("filt_hv", 64'(hv_cnt - hv0), 64'd0);
    check("filt_no_out", 64'(out_n - o0), 64'd0);
    hv0 = hv_cnt; o0 = out_n;
    send_frame(48'hFF_FF_FF_FF_FF_FF, SrcMac, 16'h0800, 3, 8'h20);
    send_frame(48'h01_00_5E_00_00_01, SrcMac, 16'h0800, 3, 8'h30);
    idle(3);
    check("filt_bc_mc_hv", 64'(hv_cnt - hv0), 64'd2);
    check("filt_mc_dst", 64'(cap_dst), 64'h01_00_5E_00_00_01);
    check("filt_bc_mc_out", 64'(out_n - o0), 64'd6);
`else
    check("nofilt_hv", 64'(hv_cnt - hv0), 64'd1);
    check("nofilt_fd", 64'(fd_cnt - fd0), 64'd0);
    check("nofilt_dst", 64'(cap_dst), 64'h02_00_00_00_00_99);
    check_payload("nofilt", o0, 5, 8'h10);
`endif

    // Reset asserted while payload byte 5 is on the input.
    send_frame(LocalMac, SrcMac, 16'h0800, 0, 8'h00);
    begin
      logic [111:0] hdr;
      hdr = {LocalMac, 48'h12_34_56_78_9A_BC, 16'h0800};
      for (int i = 0; i < 14; i++) send_byte(hdr[111-8*i -: 8], 1'b0);
      for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1'b0);
    end
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'h55;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_m_valid", 64'(m_if.tvalid), 64'd0);
    check("mid_rst_m_data", 64'(m_if.tdata), 64'd0);
    check("mid_rst_dst", 64'(hdr_dst_mac), 64'd0);
    check("mid_rst_src", 64'(hdr_src_mac), 64'd0);
    check("mid_rst_type", 64'(hdr_ethertype), 64'd0);
    check("mid_rst_s_ready", 64'(s_if.tready), 64'd1);
    s_if.tvalid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    hv0 = hv_cnt; o0 = out_n;
    send_frame(LocalMac, 48'h0A_0B_0C_0D_0E_0F, 16'h88B5, 2, 8'hC0);
    idle(3);
    check("post_rst_hv", 64'(hv_cnt - hv0), 64'd1);
    check("post_rst_dst", 64'(cap_dst), 64'(LocalMac));
    check("post_rst_src", 64'(cap_src), 64'h0A_0B_0C_0D_0E_0F);
    check("post_rst_type", 64'(cap_type), 64'h88B5);
    check_payload("post_rst", o0, 2, 8'hC0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
